// File: rtl/blk_task_scheduler_pkg.sv
// Shared definitions for the task scheduler: register offsets, IRQ bit indices
// and the sequencing FSM state type.
package blk_sched_pkg;

  localparam logic [7:0] REG_CTRL      = 8'h00;
  localparam logic [7:0] REG_STATUS    = 8'h04;
  localparam logic [7:0] REG_PARAMS_LO = 8'h08;
  localparam logic [7:0] REG_PARAMS_HI = 8'h0C;
  localparam logic [7:0] REG_PUSH      = 8'h10;
  localparam logic [7:0] REG_DONE_CNT  = 8'h14;
  localparam logic [7:0] REG_IRQ_STS   = 8'h18;

  localparam int IRQ_DONE     = 0;
  localparam int IRQ_TIMEOUT  = 1;
  localparam int IRQ_OVERFLOW = 2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN
  } sched_state_t;

endpackage

// File: rtl/blk_task_scheduler_if.sv
// ICB command/response bundle between the SoC interconnect (master) and the
// task scheduler register port (slave).
interface blk_task_scheduler_if;
  logic [31:0] cmd_addr;
  logic        cmd_read;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_valid;
  logic        rsp_ready;

  modport master (
    output cmd_addr, cmd_read, cmd_wdata, cmd_wmask, cmd_valid, rsp_ready,
    input  cmd_ready, rsp_rdata, rsp_err, rsp_valid
  );

  modport slave (
    input  cmd_addr, cmd_read, cmd_wdata, cmd_wmask, cmd_valid, rsp_ready,
    output cmd_ready, rsp_rdata, rsp_err, rsp_valid
  );
endinterface

// File: rtl/blk_task_scheduler_fifo.sv
// Synchronous task FIFO (WIDTH x DEPTH, DEPTH a power of two) with flush and
// simultaneous push/pop; push when full and pop when empty are ignored.
module blk_sched_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/blk_task_scheduler.sv
// Register-programmed task scheduler driving one compute block through its
// params/start/idle/done handshake. Define BLK_SCHED_TIMEOUT_EN for the RUN watchdog.
module blk_task_scheduler
  import blk_sched_pkg::*;
#(
  parameter int PARAMS_WIDTH   = 64,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                    clk,
  input  logic                    rst,
  blk_task_scheduler_if.slave     s_icb,
  output logic [PARAMS_WIDTH-1:0] blk_params,
  output logic                    blk_start,
  input  logic                    blk_idle,
  input  logic                    blk_done,
  output logic                    irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int HW = PARAMS_WIDTH - 32;
`ifdef BLK_SCHED_TIMEOUT_EN
  localparam logic [2:0] IRQ_MASK = 3'b111;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer;
`else
  localparam logic [2:0] IRQ_MASK = 3'b101;
`endif

  sched_state_t      state;
  logic              enable;
  logic [2:0]        irq_en;
  logic [2:0]        irq_sts;
  logic [31:0]       params_lo;
  logic [HW-1:0]     params_hi;
  logic [31:0]       done_cnt;

  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CW-1:0]           fifo_count;
  logic [PARAMS_WIDTH-1:0] fifo_rdata;
  logic                    push;
  logic                    pop;
  logic                    flush;

  logic        hs;
  logic [7:0]  addr;
  logic [31:0] rd_data;
  logic        acc_err;
  logic        wr_ctrl, wr_lo, wr_hi, wr_push, wr_w1c, push_full;
  logic [31:0] ctrl_word, status_word, hi_word;
  logic [7:0]  count8;
  logic        done_evt, timeout_evt;
  logic [2:0]  irq_set, irq_clr;
  logic        unused_bits;

  assign hs   = s_icb.cmd_valid && s_icb.cmd_ready;
  assign addr = s_icb.cmd_addr[7:0];
  assign s_icb.cmd_ready = !s_icb.rsp_valid || s_icb.rsp_ready;

  always_comb begin
    count8 = '0;
    count8[CW-1:0] = fifo_count;
    hi_word = '0;
    hi_word[HW-1:0] = params_hi;
    ctrl_word = {21'b0, irq_en, 7'b0, enable};
    status_word = {23'b0, (state != IDLE), count8};
  end

  // Address decode; misaligned, unmapped, RO-write and full-PUSH all error out.
  always_comb begin
    rd_data   = '0;
    acc_err   = 1'b0;
    wr_ctrl   = 1'b0;
    wr_lo     = 1'b0;
    wr_hi     = 1'b0;
    wr_push   = 1'b0;
    wr_w1c    = 1'b0;
    push_full = 1'b0;
    if (addr[1:0] != 2'b00) begin
      acc_err = 1'b1;
    end else begin
      case (addr)
        REG_CTRL:      if (s_icb.cmd_read) rd_data = ctrl_word; else wr_ctrl = 1'b1;
        REG_STATUS:    if (s_icb.cmd_read) rd_data = status_word; else acc_err = 1'b1;
        REG_PARAMS_LO: if (s_icb.cmd_read) rd_data = params_lo; else wr_lo = 1'b1;
        REG_PARAMS_HI: if (s_icb.cmd_read) rd_data = hi_word; else wr_hi = 1'b1;
        REG_PUSH: begin
          if (!s_icb.cmd_read) begin
            if (fifo_full) begin
              acc_err   = 1'b1;
              push_full = 1'b1;
            end else begin
              wr_push = 1'b1;
            end
          end
        end
        REG_DONE_CNT:  if (s_icb.cmd_read) rd_data = done_cnt; else acc_err = 1'b1;
        REG_IRQ_STS:   if (s_icb.cmd_read) rd_data = {29'b0, irq_sts}; else wr_w1c = 1'b1;
        default:       acc_err = 1'b1;
      endcase
    end
    if (acc_err) rd_data = '0;
  end

  assign push  = hs && wr_push;
  assign flush = hs && wr_ctrl && s_icb.cmd_wdata[1];
  assign pop   = (state == IDLE) && enable && !fifo_empty && blk_idle;

  assign done_evt = (state == RUN) && blk_done;
`ifdef BLK_SCHED_TIMEOUT_EN
  assign timeout_evt = (state == RUN) && !blk_done && (timer == TW'(TIMEOUT_CYCLES - 1));
  assign unused_bits = ^{s_icb.cmd_wmask, s_icb.cmd_addr[31:8]};
`else
  assign timeout_evt = 1'b0;
  assign unused_bits = ^{s_icb.cmd_wmask, s_icb.cmd_addr[31:8], 32'(TIMEOUT_CYCLES)};
`endif

  always_comb begin
    irq_set = '0;
    irq_set[IRQ_DONE]     = done_evt;
    irq_set[IRQ_TIMEOUT]  = timeout_evt;
    irq_set[IRQ_OVERFLOW] = hs && push_full;
    irq_set = irq_set & IRQ_MASK;
    irq_clr = (hs && wr_w1c) ? s_icb.cmd_wdata[2:0] : 3'b000;
  end

  assign irq = |(irq_sts & irq_en);

  blk_sched_fifo #(
    .WIDTH (PARAMS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({params_hi, params_lo}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // One outstanding transaction: the response holds until the master accepts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_icb.rsp_valid <= 1'b0;
      s_icb.rsp_rdata <= '0;
      s_icb.rsp_err   <= 1'b0;
    end else if (hs) begin
      s_icb.rsp_valid <= 1'b1;
      s_icb.rsp_rdata <= rd_data;
      s_icb.rsp_err   <= acc_err;
    end else if (s_icb.rsp_ready) begin
      s_icb.rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable    <= 1'b0;
      irq_en    <= '0;
      params_lo <= '0;
      params_hi <= '0;
      irq_sts   <= '0;
    end else begin
      if (hs && wr_ctrl) begin
        enable <= s_icb.cmd_wdata[0];
        irq_en <= s_icb.cmd_wdata[10:8] & IRQ_MASK;
      end
      if (hs && wr_lo) params_lo <= s_icb.cmd_wdata;
      if (hs && wr_hi) params_hi <= s_icb.cmd_wdata[HW-1:0];
      irq_sts <= (irq_sts & ~irq_clr) | irq_set;
    end
  end

  // Sequencing FSM; a new task is only popped once the FSM is back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      blk_start  <= 1'b0;
      blk_params <= '0;
      done_cnt   <= '0;
`ifdef BLK_SCHED_TIMEOUT_EN
      timer      <= '0;
`endif
    end else begin
      blk_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            blk_params <= fifo_rdata;
            blk_start  <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          state <= RUN;
`ifdef BLK_SCHED_TIMEOUT_EN
          timer <= '0;
`endif
        end
        RUN: begin
          if (done_evt) begin
            done_cnt <= done_cnt + 32'd1;
            state    <= IDLE;
          end else if (timeout_evt) begin
            state <= IDLE;
          end
`ifdef BLK_SCHED_TIMEOUT_EN
          else begin
            timer <= timer + TW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
